// File: rtl/iob_cpu_bus_arbiter_if.sv
// iob_cpu_bus_arbiter_if: IOb request/response bundle; master drives the request, slave answers it
interface iob_cpu_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                valid;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                ready;
    logic [DATA_W-1:0]   rdata;
    modport master (output valid, address, wdata, wstrb, input ready, rdata);
    modport slave (input valid, address, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/iob_cpu_bus_arbiter.sv
// iob_cpu_bus_arbiter: round-robin share of one memory port between CPU instruction and data buses
module iob_cpu_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    iob_cpu_bus_arbiter_if.slave  m0,
    iob_cpu_bus_arbiter_if.slave  m1,
    iob_cpu_bus_arbiter_if.master s,
    output logic [1:0]            grant,
    output logic                  timeout_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t              state, state_nxt;
    logic                last, win1, tmo;
    logic [15:0]         cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q, rdata_q;
    logic [DATA_W/8-1:0] wstrb_q;
    // last=1 means master 1 was served most recently, so master 0 wins a tie
    assign win1 = m1.valid && (!m0.valid || !last);
    assign tmo  = !s.ready && cnt == 16'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        s.valid   = state == REQ;
        s.address = addr_q;
        s.wdata   = wdata_q;
        s.wstrb   = state == REQ ? wstrb_q : '0;
        m0.ready  = state == RESP && grant[0];
        m1.ready  = state == RESP && grant[1];
        m0.rdata  = rdata_q;
        m1.rdata  = rdata_q;
        state_nxt = state == IDLE ? ((m0.valid || m1.valid) ? REQ : IDLE) :
                    state == REQ  ? ((s.ready || tmo) ? RESP : REQ) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant       <= 2'b00;
            cnt         <= '0;
            rdata_q     <= '0;
            timeout_err <= 1'b0;
            last        <= 1'b1;
        end else begin
            case (state)
                IDLE: if (m0.valid || m1.valid) begin
                    grant   <= {win1, !win1};
                    addr_q  <= win1 ? m1.address : m0.address;
                    wdata_q <= win1 ? m1.wdata : m0.wdata;
                    wstrb_q <= win1 ? m1.wstrb : m0.wstrb;
                end
                // a response arriving on the terminal-count cycle takes priority over the timeout
                REQ: if (s.ready) begin
                    rdata_q <= s.rdata;
                    cnt     <= '0;
                end else if (tmo) begin
                    rdata_q     <= '1;
                    timeout_err <= 1'b1;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
                RESP: begin
                    grant <= 2'b00;
                    last  <= grant[1];
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// tb_iob_cpu_bus_arbiter: directed scenarios checked against a transaction-level model every cycle
module tb_iob_cpu_bus_arbiter;
    localparam int TMO = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] grant;
    logic       timeout_err;
    always #5 clk = ~clk;
    iob_cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mi0 ();
    iob_cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mi1 ();
    iob_cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sif ();
    iob_cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .m0(mi0), .m1(mi1), .s(sif),
        .grant(grant), .timeout_err(timeout_err)
    );

    int total = 0;
    int bad = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 waiting on memory, 2 answering the owner
    int          cyc = 0, ph = 0, own = -1, prev = 1, t_req = 0;
    logic [31:0] ea, ew, er = 0;
    logic [3:0]  es;
    logic        eerr = 1'b0;
    bit          chk_en = 0;
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            ph = 0; own = -1; prev = 1; er = 0; eerr = 1'b0;
        end else if (ph == 0) begin
            if (mi0.valid || mi1.valid) begin
                own = (mi0.valid && mi1.valid) ? 1 - prev : (mi1.valid ? 1 : 0);
                ea = own == 1 ? mi1.address : mi0.address;
                ew = own == 1 ? mi1.wdata : mi0.wdata;
                es = own == 1 ? mi1.wstrb : mi0.wstrb;
                t_req = cyc;
                ph = 1;
            end
        end else if (ph == 1) begin
            if (sif.ready) begin
                er = sif.rdata; ph = 2;
            end else if (cyc - t_req == TMO) begin
                er = '1; eerr = 1'b1; ph = 2;
            end
        end else begin
            prev = own; own = -1; ph = 0;
        end
    end

    always @(negedge clk) if (chk_en) begin
        chk("s_valid", 32'(sif.valid), 32'(ph == 1));
        chk("grant", 32'(grant), own < 0 ? 32'd0 : 32'(1 << own));
        chk("m0_ready", 32'(mi0.ready), 32'(ph == 2 && own == 0));
        chk("m1_ready", 32'(mi1.ready), 32'(ph == 2 && own == 1));
        chk("timeout_err", 32'(timeout_err), 32'(eerr));
        if (ph == 1) begin
            chk("s_address", sif.address, ea);
            chk("s_wdata", sif.wdata, ew);
            chk("s_wstrb", 32'(sif.wstrb), 32'(es));
        end else chk("s_wstrb_idle", 32'(sif.wstrb), 32'd0);
        if (ph == 2) begin
            chk("m0_rdata", mi0.rdata, er);
            chk("m1_rdata", mi1.rdata, er);
        end
    end

    int          n0 = 0, n1 = 0, r0_cyc = -100, r1_cyc = -100, w = 0, slv_delay = 0, t0 = 0;
    logic [31:0] r0_data, r1_data, s_last_a, s_last_w;
    logic [3:0]  s_last_s;
    bit          hold = 0, scramble = 0;
    int          order[$];
    int          rcyc[$];

    // one cycle of master and memory behaviour, acting at the falling edge
    task automatic step();
        @(negedge clk);
        if (mi0.ready) begin
            n0++; r0_cyc = cyc; r0_data = mi0.rdata; order.push_back(0); rcyc.push_back(cyc);
            if (!hold) mi0.valid = 1'b0;
        end
        if (mi1.ready) begin
            n1++; r1_cyc = cyc; r1_data = mi1.rdata; order.push_back(1); rcyc.push_back(cyc);
            if (!hold) mi1.valid = 1'b0;
        end
        if (sif.valid) begin
            s_last_a = sif.address; s_last_w = sif.wdata; s_last_s = sif.wstrb;
            if (scramble) begin
                mi0.address = 32'hDEAD; mi0.wdata = 32'h0; mi0.wstrb = 4'hF;
            end
            sif.ready = slv_delay >= 0 && w == slv_delay;
            w++;
        end else begin
            w = 0; sif.ready = 1'b0;
        end
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        if (m == 0) begin
            mi0.valid = 1'b1; mi0.address = a; mi0.wdata = d; mi0.wstrb = st;
        end else begin
            mi1.valid = 1'b1; mi1.address = a; mi1.wdata = d; mi1.wstrb = st;
        end
    endtask

    task automatic wait_done(input string nm, input int m, input int budget);
        int st = m == 1 ? n1 : n0;
        int k = 0;
        while ((m == 1 ? n1 : n0) == st && k < budget) begin
            step();
            k++;
        end
        chk(nm, 32'(k < budget), 32'd1);
    endtask

    initial begin
        mi0.valid = 0; mi0.address = 0; mi0.wdata = 0; mi0.wstrb = 0;
        mi1.valid = 0; mi1.address = 0; mi1.wdata = 0; mi1.wstrb = 0;
        sif.ready = 0; sif.rdata = 0;
        repeat (2) step();
        chk_en = 1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_valid", 32'(sif.valid), 32'd0);
        chk("rst_s_wstrb", 32'(sif.wstrb), 32'd0);
        chk("rst_ready", 32'({mi1.ready, mi0.ready}), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        step();
        // tie right after reset: master 0 first, master 1 three cycles later
        slv_delay = 0; sif.rdata = 32'h11;
        req(0, 32'h10, 32'h0, 4'h0); req(1, 32'h14, 32'h0, 4'h0); t0 = cyc;
        step(); chk("tie_grant_a", 32'(grant), 32'd1);
        step(); chk("tie_m0_lat", 32'(r0_cyc - t0), 32'd2);
        step(); step(); chk("tie_grant_b", 32'(grant), 32'd2);
        step(); chk("tie_m1_lat", 32'(r1_cyc - t0), 32'd5);
        step();
        // read with 3 wait cycles; response lands on the terminal-count cycle
        slv_delay = 3; sif.rdata = 32'hCAFEF00D;
        req(1, 32'h100, 32'h0, 4'h0); t0 = cyc;
        wait_done("rd_done", 1, 20);
        chk("rd_data", r1_data, 32'hCAFEF00D);
        chk("rd_lat", 32'(r1_cyc - t0), 32'd5);
        chk("rd_addr", s_last_a, 32'h100);
        chk("rd_wstrb", 32'(s_last_s), 32'd0);
        step();
        chk("rd_one_pulse", 32'(mi1.ready), 32'd0);
        chk("rd_no_err", 32'(timeout_err), 32'd0);
        // write whose master payload changes while the request is outstanding
        slv_delay = 2; scramble = 1;
        req(0, 32'h200, 32'hA5A5A5A5, 4'h3);
        wait_done("wr_done", 0, 20);
        scramble = 0;
        chk("wr_wdata", s_last_w, 32'hA5A5A5A5);
        chk("wr_wstrb", 32'(s_last_s), 32'd3);
        chk("wr_addr", s_last_a, 32'h200);
        step();
        // slave never answers
        slv_delay = -1;
        req(0, 32'h300, 32'h0, 4'h0); t0 = cyc;
        wait_done("to_done", 0, 20);
        chk("to_lat", 32'(r0_cyc - t0), 32'd5);
        chk("to_data", r0_data, 32'hFFFFFFFF);
        chk("to_err", 32'(timeout_err), 32'd1);
        step();
        slv_delay = 0; sif.rdata = 32'h12345678;
        req(1, 32'h304, 32'h0, 4'h0);
        wait_done("after_to_done", 1, 20);
        chk("after_to_data", r1_data, 32'h12345678);
        chk("err_sticky", 32'(timeout_err), 32'd1);
        step();
        // both masters stream continuously
        hold = 1; order.delete(); rcyc.delete(); sif.rdata = 32'h55;
        req(0, 32'h500, 32'h0, 4'h0); req(1, 32'h504, 32'h0, 4'h0);
        for (int k = 0; k < 40 && order.size() < 6; k++) step();
        hold = 0; mi0.valid = 1'b0; mi1.valid = 1'b0;
        chk("fair_count", 32'(order.size()), 32'd6);
        if (order.size() == 6) begin
            for (int i = 0; i < 6; i++) chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
            chk("fair_rate", 32'(rcyc[5] - rcyc[0]), 32'd15);
        end
        step(); step();
        // reset while the memory request is outstanding
        slv_delay = -1;
        req(0, 32'h400, 32'h0, 4'h0);
        step(); step();
        chk("mid_in_req", 32'(sif.valid), 32'd1);
        rst = 1'b0; mi0.valid = 1'b0; t0 = n0 + n1;
        step();
        chk("mid_s_valid", 32'(sif.valid), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        chk("mid_err", 32'(timeout_err), 32'd0);
        rst = 1'b1;
        repeat (4) step();
        chk("mid_no_ready", 32'(n0 + n1 - t0), 32'd0);
        slv_delay = 0; sif.rdata = 32'h77;
        req(0, 32'h404, 32'h0, 4'h0); t0 = cyc;
        wait_done("reissue_done", 0, 20);
        chk("reissue_lat", 32'(r0_cyc - t0), 32'd2);
        chk("reissue_data", r0_data, 32'h77);
        repeat (2) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule

// File: doc/iob_cpu_bus_arbiter.md
IOB_CPU_BUS_ARBITER -- requirements
Module: iob_cpu_bus_arbiter

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 32, giving the address width.
REQ-002 The block SHALL have the parameter DATA_W, default 32, giving the data width; the strobe width is DATA_W/8.
REQ-003 The block SHALL have the parameter TIMEOUT, default 255, giving the maximum slave wait in cycles (range 2..65535).
REQ-004 The block SHALL have clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-005 The block SHALL have rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have m0_valid/m0_address/m0_wdata/m0_wstrb, inputs, 1/ADDR_W/DATA_W/DATA_W/8 bits: master 0 (CPU instruction bus) request.
REQ-007 The block SHALL have m0_ready/m0_rdata, outputs, 1/DATA_W bits: master 0 response.
REQ-008 The block SHALL have m1_valid/m1_address/m1_wdata/m1_wstrb, inputs: master 1 (CPU data bus) request, with the same widths as master 0.
REQ-009 The block SHALL have m1_ready/m1_rdata, outputs: master 1 response.
REQ-010 The block SHALL have s_valid/s_address/s_wdata/s_wstrb, outputs, 1/ADDR_W/DATA_W/DATA_W/8 bits: shared memory request.
REQ-011 The block SHALL have s_ready/s_rdata, inputs, 1/DATA_W bits: shared memory response.
REQ-012 The block SHALL have grant, output, 2 bits: one-hot owner of the current transaction, 0 when idle.
REQ-013 The block SHALL have timeout_err, output, 1 bit: sticky slave-timeout flag.

Function
REQ-014 The block SHALL implement three states, IDLE, REQ and RESP, encoded as registered state.
REQ-015 In IDLE with no mN_valid set, the block SHALL stay in IDLE with s_valid=0.
REQ-016 In IDLE with at least one mN_valid set, the block SHALL select a winner, register its address, wdata and wstrb, set grant, and go to REQ.
REQ-017 Arbitration SHALL be round-robin: a sole requester wins; when both request, the master not granted last wins.
REQ-018 The last-granted pointer SHALL update only on the transition out of RESP.
REQ-019 In REQ, s_valid SHALL be 1 and s_address/s_wdata/s_wstrb SHALL equal the registered request, held stable until the cycle s_ready is sampled.
REQ-020 In REQ with s_ready=1, the block SHALL capture s_rdata into the response register, clear the wait counter, and go to RESP.
REQ-021 In REQ, the wait counter SHALL increment each cycle without s_ready.
REQ-022 When the wait counter reaches TIMEOUT-1 without s_ready, the block SHALL load all-ones into the response register, set timeout_err, and go to RESP.
REQ-023 If s_ready arrives in the same cycle the timeout terminal count is reached, s_ready SHALL win and timeout_err SHALL be unchanged.
REQ-024 In RESP, the granted master's ready SHALL be 1 for exactly one cycle, and the other master's ready SHALL be 0.
REQ-025 In RESP, the block SHALL go to IDLE unconditionally and clear grant.
REQ-026 m0_rdata and m1_rdata SHALL both equal the response register; they are meaningful only with the corresponding ready.
REQ-027 Each master SHALL hold valid and its payload until its ready; the block SHALL ignore payload changes after the request is registered.
REQ-028 A non-granted master's valid SHALL remain pending and SHALL be served no later than the next arbitration.
REQ-029 Minimum latency from mN_valid to mN_ready SHALL be 2 cycles (valid at t, s_valid at t+1, s_ready at t+1, ready at t+2).
REQ-030 Back-to-back requests SHALL sustain at most one transaction per 3 cycles.
REQ-031 Outside REQ, s_wstrb SHALL be 0 and s_valid SHALL be 0.
REQ-032 timeout_err SHALL be cleared only by reset.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL enter IDLE and clear grant, s_valid, s_wstrb, m0_ready, m1_ready, timeout_err, the wait counter and the response register.
REQ-034 After reset, the last-granted pointer SHALL be set to master 1, so master 0 wins the first tie.
REQ-035 A reset asserted mid-transaction SHALL abort it with no ready issued; masters re-issue after reset.

Verification
REQ-036 Tie after reset: m0 and m1 valid at cycle 0, s_ready tied 1 -> m0 sees ready at cycle 2, then m1 sees ready at cycle 5; grant goes 01 then 10.
REQ-037 Read data: m1 reads 0x100 and the slave returns 0xCAFEF00D after 3 wait cycles -> m1_rdata=0xCAFEF00D with m1_ready high for one cycle; s_address=0x100, s_wstrb=0.
REQ-038 Write hold: m0 writes 0xA5A5A5A5 with wstrb 0x3, and the master changes its payload during REQ -> s_wdata/s_wstrb stay 0xA5A5A5A5/0x3 until s_ready.
REQ-039 Timeout: TIMEOUT=4, s_ready held 0 -> ready 4 cycles into REQ with rdata 0xFFFFFFFF and timeout_err=1; the next normal transaction completes and timeout_err stays 1.
REQ-040 Fairness: both masters hold valid continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1.
REQ-041 Reset mid-REQ: rst=0 during REQ -> next cycle state IDLE, s_valid=0, no ready pulses, timeout_err=0.
